// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module   : writeback
// Purpose  : Register-file write-port arbiter. ALU results take priority;
//            load results are buffered in a small FIFO and drained when the
//            port is idle. A pending-load scoreboard flags registers that
//            still wait on a load.
// Revision : 1.0 - initial release
// ============================================================================
module writeback #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_issue,
  input  logic [4:0]  lsu_issue_rd,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic [4:0]  rs1_select,
  input  logic [4:0]  rs2_select,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  reg_write_select,
  output logic [31:0] reg_write_data,
  output logic        reg_write_control
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]   fifo_rd_q   [DEPTH];
  logic [4:0]   fifo_rd_d   [DEPTH];
  logic [31:0]  fifo_data_q [DEPTH];
  logic [31:0]  fifo_data_d [DEPTH];
  // Bit 0 exists only to keep indexing by register number simple; it stays 0.
  logic [31:0]  pending_q, pending_d;
  logic [4:0]   sel_q, sel_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         ctrl_q, ctrl_d;

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [4:0]   head_rd;
  logic [31:0]  head_data;

  // FIFO status and handshake decisions; ready depends on occupancy only.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push      = lsu_valid && !full;
    pop       = !alu_valid && !empty;
    head_rd   = fifo_rd_q[rd_ptr_q[AW-1:0]];
    head_data = fifo_data_q[rd_ptr_q[AW-1:0]];
  end

  assign lsu_ready = !full;
  assign rs1_busy  = pending_q[rs1_select];
  assign rs2_busy  = pending_q[rs2_select];

  assign reg_write_select  = sel_q;
  assign reg_write_data    = wdata_q;
  assign reg_write_control = ctrl_q;

  // Next-state: FIFO storage/pointers, scoreboard, and the write-port register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    pending_d   = pending_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    ctrl_d      = 1'b0;

    if (push) begin
      fifo_rd_d[wr_ptr_q[AW-1:0]]   = lsu_rd;
      fifo_data_d[wr_ptr_q[AW-1:0]] = lsu_data;
      wr_ptr_d                      = wr_ptr_q + 1'b1;
    end

    if (alu_valid) begin
      sel_d   = alu_rd;
      wdata_d = alu_data;
      ctrl_d  = (alu_rd != 5'd0);
    end else if (pop) begin
      sel_d    = head_rd;
      wdata_d  = head_data;
      ctrl_d   = (head_rd != 5'd0);
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Clear first so that a same-cycle issue to the same register wins.
    if (pop && head_rd != 5'd0) begin
      pending_d[head_rd] = 1'b0;
    end
    if (lsu_issue && lsu_issue_rd != 5'd0) begin
      pending_d[lsu_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset drops buffered loads and all pending bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      ctrl_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
    end
  end

endmodule
`default_nettype wire
